// File: rtl/alu_pkg.sv
// ============================================================================
// alu_pkg : ops encoding shared with the ALU control decoder, alu_seq FSM states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam logic [3:0] OP_AND     = 4'b0000;
  localparam logic [3:0] OP_OR      = 4'b0001;
  localparam logic [3:0] OP_ADD     = 4'b0010;
  localparam logic [3:0] OP_MOD     = 4'b0011;
  localparam logic [3:0] OP_NOR     = 4'b0100;
  localparam logic [3:0] OP_MUL     = 4'b0101;
  localparam logic [3:0] OP_SUB     = 4'b0110;
  localparam logic [3:0] OP_XOR     = 4'b0111;
  localparam logic [3:0] OP_DIV     = 4'b1000;
  localparam logic [3:0] OP_SLT     = 4'b1001;
  localparam logic [3:0] OP_UNDEF   = 4'b1010;
  localparam logic [3:0] OP_GEZ     = 4'b1011;
  localparam logic [3:0] OP_BITSWAP = 4'b1100;
  localparam logic [3:0] OP_BNE     = 4'b1101;
  localparam logic [3:0] OP_LUI     = 4'b1110;
  localparam logic [3:0] OP_NOP     = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
// ============================================================================
// alu_muldiv_iter : iterative shift-add multiplier / restoring divider, WIDTH steps
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ops,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // mul: acc = partial product, x = multiplicand, y = multiplier
  // div: acc = remainder,       x = divisor,      y = dividend shifting into quotient
  logic             active_q, active_d;
  logic             div_q, div_d;
  logic             rem_sel_q, rem_sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_last;

  assign w_last    = (cnt_q == CNT_W'(WIDTH - 1));
  assign w_shifted = {acc_q, y_q[WIDTH-1]};
  assign w_trial   = w_shifted - {1'b0, x_q};

  always_comb begin
    active_d  = active_q;
    div_d     = div_q;
    rem_sel_d = rem_sel_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    x_d       = x_q;
    y_d       = y_q;
    if (start) begin
      active_d  = 1'b1;
      div_d     = (ops != OP_MUL);
      rem_sel_d = (ops == OP_MOD);
      cnt_d     = '0;
      acc_d     = '0;
      x_d       = (ops == OP_MUL) ? a : b;
      y_d       = (ops == OP_MUL) ? b : a;
    end else if (active_q) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_q) begin
        // A borrow out of the trial subtraction means the divisor did not fit.
        if (!w_trial[WIDTH]) begin
          acc_d = w_trial[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = w_shifted[WIDTH-1:0];
          y_d   = {y_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc_d = acc_q + (y_q[0] ? x_q : '0);
        x_d   = x_q << 1;
        y_d   = y_q >> 1;
      end
      if (w_last) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q  <= 1'b0;
      div_q     <= 1'b0;
      rem_sel_q <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      active_q  <= active_d;
      div_q     <= div_d;
      rem_sel_q <= rem_sel_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  // Result of the final step is offered combinationally so the FSM can register it on the same edge.
  assign done   = active_q && w_last;
  assign result = (div_q && !rem_sel_q) ? y_d : acc_d;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : multi-cycle ALU with start/done handshake; ALU_OVF_EN adds ovf output
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       ops,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy,
  output logic             done
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_swap;

  assign w_sum  = a + b;
  assign w_diff = a - b;

  always_comb begin
    w_swap = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_swap[i] = a[WIDTH-1-i];
    end
  end

  always_comb begin
    single_res = '0;
    case (ops)
      OP_AND:     single_res = a & b;
      OP_OR:      single_res = a | b;
      OP_ADD:     single_res = w_sum;
      OP_NOR:     single_res = ~(a | b);
      OP_SUB:     single_res = w_diff;
      OP_XOR:     single_res = a ^ b;
      OP_SLT:     single_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_GEZ:     single_res = {{(WIDTH-1){1'b0}}, ~a[WIDTH-1]};
      OP_BITSWAP: single_res = w_swap;
      OP_BNE:     single_res = {{(WIDTH-1){1'b0}}, (a != b)};
      OP_LUI:     single_res = b << (WIDTH / 2);
      default:    single_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  logic ovf_q, ovf_d;
  logic single_ovf;

  always_comb begin
    single_ovf = 1'b0;
    if (ops == OP_ADD) begin
      single_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    end else if (ops == OP_SUB) begin
      single_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    md_start = 1'b0;
`ifdef ALU_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (ops == OP_MUL || ops == OP_DIV || ops == OP_MOD) begin
            md_start = 1'b1;
            busy_d   = 1'b1;
            state_d  = (ops == OP_MUL) ? MUL : DIV;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            done_d   = 1'b1;
            state_d  = DONE;
`ifdef ALU_OVF_EN
            ovf_d    = single_ovf;
`endif
          end
        end
      end
      MUL, DIV: begin
        if (md_done) begin
          result_d = md_result;
          zero_d   = (md_result == '0);
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = DONE;
`ifdef ALU_OVF_EN
          ovf_d    = 1'b0;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .ops    (ops),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_result)
  );

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef ALU_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// tb_alu_seq : directed plus randomized operations against an arithmetic reference model.
`default_nettype none

module tb_alu_seq;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [3:0]       ops = 4'd0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic             done;
`ifdef ALU_OVF_EN
  logic             ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .ops    (ops),
    .a      (a),
    .b      (b),
    .result (result),
    .zero   (zero),
    .busy   (busy),
    .done   (done)
`ifdef ALU_OVF_EN
    ,
    .ovf    (ovf)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [3:0] op,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    r = '0;
    case (op)
      OP_AND:     r = x & y;
      OP_OR:      r = x | y;
      OP_ADD:     r = x + y;
      OP_MOD:     r = (y == 0) ? x : x % y;
      OP_NOR:     r = ~(x | y);
      OP_MUL:     r = x * y;
      OP_SUB:     r = x - y;
      OP_XOR:     r = x ^ y;
      OP_DIV:     r = (y == 0) ? '1 : x / y;
      OP_SLT:     r = ($signed(x) < $signed(y)) ? 1 : 0;
      OP_GEZ:     r = ($signed(x) >= 0) ? 1 : 0;
      OP_BITSWAP: for (int i = 0; i < WIDTH; i++) r[WIDTH-1-i] = x[i];
      OP_BNE:     r = (x != y) ? 1 : 0;
      OP_LUI:     r = y << (WIDTH / 2);
      default:    r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_OVF_EN
  function automatic logic model_ovf(input logic [3:0] op,
                                     input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    longint sx, sy, s, lim;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lim = longint'(1) << (WIDTH - 1);
    if (op == OP_ADD)      s = sx + sy;
    else if (op == OP_SUB) s = sx - sy;
    else return 1'b0;
    return (s > lim - 1) || (s < -lim);
  endfunction
`endif

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 1;
      2:       return '1;
      3:       return {1'b1, {(WIDTH-1){1'b0}}};
      4:       return {1'b0, {(WIDTH-1){1'b1}}};
      5:       return WIDTH'($urandom_range(0, 15));
      default: return WIDTH'($urandom);
    endcase
  endfunction

  // noise: random start pulses and operand changes while the op runs; poke: start held in the DONE cycle.
  task automatic run_op(input logic [3:0] op, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input bit noise, input bit poke, input string tag);
    logic [WIDTH-1:0] exp_r;
    bit multi;
    int exp_lat, lat, busy_err;
    exp_r   = model(op, x, y);
    multi   = (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
    exp_lat = multi ? WIDTH + 1 : 1;
    lat      = 0;
    busy_err = 0;
    @(negedge clk);
    start = 1'b1; ops = op; a = x; b = y;
    @(posedge clk);
    for (int k = 1; k <= WIDTH + 8 && lat == 0; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        if (busy !== 1'b0) busy_err++;
        start = poke;
        ops   = OP_ADD;
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
      end else begin
        if (busy !== ((multi && k <= WIDTH) ? 1'b1 : 1'b0)) busy_err++;
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          ops   = 4'($urandom);
          a     = WIDTH'($urandom);
          b     = WIDTH'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    check($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.result", tag), 64'(result), 64'(exp_r));
    check($sformatf("%s.zero", tag), 64'(zero), 64'(exp_r == '0));
    check($sformatf("%s.busy_errs", tag), 64'(busy_err), 64'd0);
`ifdef ALU_OVF_EN
    check($sformatf("%s.ovf", tag), 64'(ovf), 64'(model_ovf(op, x, y)));
`endif
    if (poke) begin
      @(negedge clk);
      start = 1'b0;
      check($sformatf("%s.poke_done", tag), 64'(done), 64'd0);
      check($sformatf("%s.poke_busy", tag), 64'(busy), 64'd0);
      check($sformatf("%s.poke_hold", tag), 64'(result), 64'(exp_r));
    end
  endtask

  initial begin
    int done_cnt;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.result", 64'(result), 64'd0);
    check("rst.zero", 64'(zero), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
`ifdef ALU_OVF_EN
    check("rst.ovf", 64'(ovf), 64'd0);
`endif

    // reset wins over a simultaneous start
    start = 1'b1; ops = OP_ADD; a = 5; b = 7;
    @(negedge clk);
    check("rst_vs_start.done", 64'(done), 64'd0);
    check("rst_vs_start.result", 64'(result), 64'd0);
    rst = 1'b0; start = 1'b0;

    run_op(OP_ADD, 5, 7, 1'b0, 1'b0, "add");
    run_op(OP_SUB, 9, 9, 1'b0, 1'b0, "sub0");
    run_op(OP_SLT, '1, 1, 1'b0, 1'b1, "slt");
    run_op(OP_MUL, 1234, 5678, 1'b1, 1'b0, "mul");
    check("mul.value", 64'(result), 64'd7006652);

    // abort a multiply with reset in cycle N+10
    @(negedge clk);
    start = 1'b1; ops = OP_MUL; a = 77; b = 99;
    @(posedge clk);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.done", 64'(done), 64'd0);
    check("abort.result", 64'(result), 64'd0);
    check("abort.zero", 64'(zero), 64'd1);
    rst = 1'b0;
    done_cnt = 0;
    repeat (WIDTH + 5) begin
      @(negedge clk);
      if (done !== 1'b0) done_cnt++;
    end
    check("abort.no_done", 64'(done_cnt), 64'd0);

    run_op(OP_DIV, 100, 7, 1'b0, 1'b0, "div");
    run_op(OP_MOD, 100, 7, 1'b0, 1'b0, "mod");
    run_op(OP_DIV, 5, 0, 1'b1, 1'b0, "div0");
    run_op(OP_MOD, 5, 0, 1'b0, 1'b1, "mod0");
    run_op(OP_LUI, 0, 32'h1234, 1'b0, 1'b0, "lui");
    run_op(OP_BITSWAP, 1, 0, 1'b0, 1'b0, "bitswap");
    run_op(OP_UNDEF, 32'hdead, 32'hbeef, 1'b0, 1'b0, "undef");
    run_op(OP_GEZ, 32'h8000_0000, 0, 1'b0, 1'b0, "gez_neg");
    run_op(OP_ADD, 32'h7fff_ffff, 1, 1'b0, 1'b0, "add_ovf");
    run_op(OP_SUB, 32'h8000_0000, 1, 1'b0, 1'b0, "sub_ovf");

    for (int i = 0; i < 150; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    @(negedge clk);
    start = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle ALU datapath: consumes the 4-bit ALU operation select `ops` that the ALU control decoder produces, together with operands a/b.
- Single-cycle ops (logic, add/sub, compare, shifts) complete in 1 cycle.
- mul, div and mod run iteratively, WIDTH cycles each.
- A start/done handshake lets the datapath controller stall while the ALU is busy.

Parameters:
WIDTH, 32, operand/result width in bits; must be even and >= 8.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  pulse; accept ops/a/b when idle
ops  input  4  ALU operation select (encoding under Behaviour)
a  input  WIDTH  operand A (rs)
b  input  WIDTH  operand B (rt / immediate)
result  output  WIDTH  registered result, held until next accepted start
zero  output  1  registered; 1 when result == 0
busy  output  1  1 from the cycle after acceptance until done
done  output  1  one-cycle pulse when result/zero are valid

Behaviour:
- Reset (synchronous, active-high):
  - result=0, zero=1, busy=0, done=0, state=IDLE, counter=0.
  - rst dominates start in the same cycle.
  - rst mid-operation aborts it; no done is produced.
- Acceptance:
  - start is sampled only in IDLE; ops, a, b are latched on the accept edge.
  - start while busy=1 or in DONE is ignored (not queued).
- ops encoding:
  - 0000 a&b; 0001 a|b; 0010 a+b; 0011 a%b; 0100 ~(a|b); 0101 a*b (low WIDTH bits); 0110 a-b; 0111 a^b; 1000 a/b
  - 1001 slt: 1 if signed a < signed b, else 0
  - 1011 gez: 1 if signed a >= 0, else 0
  - 1100 bitswap: bit-reverse of a
  - 1101 bne: 1 if a != b, else 0
  - 1110 lui: b << (WIDTH/2)
  - 1111 nop: result 0
  - 1010 (undefined): treated as nop
- Arithmetic: add/sub wrap modulo 2^WIDTH; mul, div and mod are unsigned.
- FSM states:
  - IDLE: on start with a single-cycle op, compute and register result → DONE. On start with 0101 → MUL; with 1000 or 0011 → DIV. counter=0.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, for WIDTH cycles → DONE.
  - DIV: restoring division, one quotient bit per cycle, MSB first, for WIDTH cycles → DONE. Selects quotient (1000) or remainder (0011).
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE. result/zero remain stable.
- Latency (accept edge = cycle N):
  - single-cycle op: done=1 in cycle N+1.
  - mul/div/mod: done=1 in cycle N+WIDTH+1; busy=1 for cycles N+1..N+WIDTH.
- Divide by zero: quotient = all ones, remainder = a. Still takes full latency, no error flag.
- Back-to-back: the earliest next accept is the cycle after done, i.e. state is IDLE again.
- zero is updated only together with result, in the cycle done asserts.

Optional Feature:
ALU_OVF_EN:
- Defined:
  - adds output port ovf (1 bit), reset 0, updated with result.
  - For 0010: ovf=1 on signed overflow (a, b same sign; result sign differs).
  - For 0110: ovf=1 on signed overflow (a, b signs differ; result sign differs from a).
  - All other ops: ovf=0.
- Undefined: no ovf port or logic; behaviour otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - localparams for every ops code (OP_AND … OP_NOP).
  - FSM state enum (IDLE, MUL, DIV, DONE).
- Shared with the ALU control decoder so both ends use one encoding.
- One sub-module: alu_muldiv_iter, the iterative multiplier/divider datapath and counter, with a start/done interface to the alu_seq FSM. Single-cycle ops stay in alu_seq.

Test Plan:
- Add: a=5, b=7, ops=0010, start at N → done at N+1, result=12, zero=0.
- Sub to zero, then slt: a=9, b=9, ops=0110 → result=0, zero=1. Then a=0xFFFFFFFF (-1), b=1, ops=1001 → result=1.
- Multiply: a=1234, b=5678, ops=0101, start at N → busy N+1..N+32, done at N+33, result=7006652. start pulses during busy are ignored and the result is unchanged.
- Divide and mod: a=100, b=7, ops=1000 → 14; ops=0011 → 2. done at N+33 each; second start issued the cycle after the first done.
- Divide by zero: a=5, b=0, ops=1000 → 0xFFFFFFFF; ops=0011 → 5.
- Reset mid-operation and special ops:
  - rst asserted at N+10 of a mul → next cycle busy=0, done=0, result=0, zero=1; no done follows.
  - lui b=0x1234 → 0x12340000.
  - bitswap a=0x00000001 → 0x80000000.
  - ALU_OVF_EN build: 0x7FFFFFFF+1 → ovf=1.
